// File: rtl/hazard_scoreboard.sv
// D-stage hazard/stall unit: per-register countdown of cycles until a pending
// write becomes forwardable, MDU occupancy counter and saturating stall counter.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int N_SRC    = 2,
  parameter int TW       = 3,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  input  logic                flush,
  input  logic                d_valid,
  input  logic [N_SRC*AW-1:0] d_src,
  input  logic [N_SRC-1:0]    d_src_use,
  input  logic [N_SRC*TW-1:0] d_tuse,
  input  logic                d_we,
  input  logic [AW-1:0]       d_dst,
  input  logic [TW-1:0]       d_tnew,
  input  logic                d_md,
  input  logic                d_md_div,
  input  logic                d_mdu_use,
  output logic                stall,
  output logic [1:0]          stall_why,
  output logic                mdu_busy,
  output logic [CNT_W-1:0]    stall_count
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int MW      = $clog2(MAX_LAT + 1);
  localparam logic [MW-1:0] L_MULT = MW'(MULT_LAT);
  localparam logic [MW-1:0] L_DIV  = MW'(DIV_LAT);

  logic [TW-1:0]    r_sb [NREG];
  logic [MW-1:0]    r_mdu_cnt;
  logic [CNT_W-1:0] r_stall_count;

  logic w_reg_haz;
  logic w_mdu_haz;
  logic w_issue;
  logic w_load;

  // Handshake: the D instruction leaves D on a cycle with d_valid=1, stall=0,
  // hold=0 and flush=0; otherwise the front end keeps presenting it unchanged.
  always_comb begin
    w_reg_haz = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (d_src_use[i] && (d_src[i*AW +: AW] != '0) &&
          (r_sb[d_src[i*AW +: AW]] > d_tuse[i*TW +: TW]))
        w_reg_haz = 1'b1;
    end
  end

  assign w_mdu_haz   = d_valid & d_mdu_use & (r_mdu_cnt != '0);
  assign stall       = d_valid & (w_reg_haz | w_mdu_haz);
  assign stall_why   = {w_mdu_haz, d_valid & w_reg_haz};
  assign mdu_busy    = (r_mdu_cnt != '0);
  assign stall_count = r_stall_count;

  assign w_issue = d_valid & ~stall & ~hold & ~flush;
  assign w_load  = w_issue & d_we & (d_dst != '0) & (d_tnew != '0);

  // A new load overrides the same-cycle decrement of its own entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) r_sb[r] <= '0;
    end else if (!hold) begin
      for (int r = 0; r < NREG; r++) begin
        if (flush)
          r_sb[r] <= '0;
        else if (w_load && (d_dst == AW'(r)))
          r_sb[r] <= d_tnew;
        else if (r_sb[r] != '0)
          r_sb[r] <= r_sb[r] - 1'b1;
      end
    end
  end

  // A started MDU operation always completes, so flush does not touch it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_mdu_cnt <= '0;
    else if (!hold) begin
      if (w_issue && d_md)
        r_mdu_cnt <= d_md_div ? L_DIV : L_MULT;
      else if (r_mdu_cnt != '0)
        r_mdu_cnt <= r_mdu_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall_count <= '0;
    else if (stall && !hold && (r_stall_count != '1))
      r_stall_count <= r_stall_count + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard (CNT_W=4): directed pipeline scenarios plus random
// stimulus, compared with a ready-time model of pending writes and MDU completion.
module tb_hazard_scoreboard;

  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int N_SRC = 2;
  localparam int TW    = 3;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic                clk = 1'b0;
  logic                reset;
  logic                hold, flush, d_valid, d_we, d_md, d_md_div, d_mdu_use;
  logic [N_SRC*AW-1:0] d_src;
  logic [N_SRC-1:0]    d_src_use;
  logic [N_SRC*TW-1:0] d_tuse;
  logic [AW-1:0]       d_dst;
  logic [TW-1:0]       d_tnew;
  logic                stall, mdu_busy;
  logic [1:0]          stall_why;
  logic [CNT_W-1:0]    stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: each register / the MDU is "ready" at an effective cycle number;
  // the effective clock only advances on cycles without hold.
  int teff;
  int ready [NREG];
  int mdu_ready;
  int m_cnt;
  logic [7:0] exp_q[$];

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .N_SRC(N_SRC), .TW(TW),
                      .MULT_LAT(5), .DIV_LAT(10), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .d_valid(d_valid),
    .d_src(d_src), .d_src_use(d_src_use), .d_tuse(d_tuse), .d_we(d_we),
    .d_dst(d_dst), .d_tnew(d_tnew), .d_md(d_md), .d_md_div(d_md_div),
    .d_mdu_use(d_mdu_use), .stall(stall), .stall_why(stall_why),
    .mdu_busy(mdu_busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int sb_of(input int r);
    return (ready[r] > teff) ? ready[r] - teff : 0;
  endfunction

  function automatic logic [1:0] m_why();
    logic rh, mh;
    int src;
    rh = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      src = int'(d_src[i*AW +: AW]);
      if (d_src_use[i] && src != 0 && sb_of(src) > int'(d_tuse[i*TW +: TW])) rh = 1'b1;
    end
    mh = d_mdu_use && (mdu_ready > teff);
    return d_valid ? {mh, rh} : 2'b00;
  endfunction

  task automatic model_clear();
    teff = 0;
    mdu_ready = 0;
    m_cnt = 0;
    for (int r = 0; r < NREG; r++) ready[r] = 0;
  endtask

  task automatic set_d(input logic v, input int s0, input int s1, input logic [1:0] use_,
                       input int tu0, input int tu1, input logic we, input int dst,
                       input int tnew, input logic md, input logic dv, input logic mu);
    d_valid   = v;
    d_src     = {AW'(s1), AW'(s0)};
    d_src_use = use_;
    d_tuse    = {TW'(tu1), TW'(tu0)};
    d_we      = we;
    d_dst     = AW'(dst);
    d_tnew    = TW'(tnew);
    d_md      = md;
    d_md_div  = dv;
    d_mdu_use = mu;
  endtask

  task automatic idle();
    set_d(1'b0, 0, 0, 2'b00, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    hold  = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
  endtask

  // One clock: check outputs at negedge, then advance the model at posedge.
  task automatic step();
    logic [1:0] why;
    logic       st, issue;
    logic [7:0] e;
    @(negedge clk);
    why = m_why();
    st  = |why;
    exp_q.push_back({m_cnt[3:0], logic'(mdu_ready > teff), why, st});
    e = exp_q.pop_front();
    chk("stall", 32'(stall), 32'(e[0]));
    chk("stall_why", 32'(stall_why), 32'(e[2:1]));
    chk("mdu_busy", 32'(mdu_busy), 32'(e[3]));
    chk("stall_count", 32'(stall_count), 32'(e[7:4]));
    @(posedge clk);
    if (!hold) begin
      issue = d_valid && !st && !flush;
      teff++;
      if (flush) begin
        for (int r = 0; r < NREG; r++) ready[r] = 0;
      end else if (issue && d_we && d_dst != 0 && d_tnew != 0)
        ready[d_dst] = teff + int'(d_tnew);
      if (issue && d_md) mdu_ready = teff + (d_md_div ? 10 : 5);
      if (st && m_cnt < SAT) m_cnt++;
    end
    #1;
  endtask

  task automatic lw(input int dst, input int tnew);
    set_d(1'b1, 0, 0, 2'b00, 0, 0, 1'b1, dst, tnew, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mdop(input logic dv);
    set_d(1'b1, 0, 0, 2'b00, 0, 0, 1'b0, 0, 0, 1'b1, dv, 1'b1);
  endtask

  task automatic mfhi();
    set_d(1'b1, 0, 0, 2'b00, 0, 0, 1'b1, 4, 1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    model_clear();
    do_reset();
    chk("reset_stall", 32'(stall), 0);
    chk("reset_count", 32'(stall_count), 0);

    // lw $1 (tnew 2) then addu $2,$1,$3 (tuse 1): one stall cycle
    lw(1, 2); step();
    set_d(1'b1, 1, 3, 2'b11, 1, 1, 1'b1, 2, 1, 1'b0, 1'b0, 1'b0);
    step(); step();
    idle(); step();
    chk("t1_count", 32'(stall_count), 1);

    // lw $1 then beq $1,$0 (tuse 0): two stall cycles; with $0 only, none
    do_reset();
    lw(1, 2); step();
    set_d(1'b1, 1, 0, 2'b11, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    chk("t2_count", 32'(stall_count), 2);
    do_reset();
    lw(1, 2); step();
    set_d(1'b1, 0, 0, 2'b11, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    chk("t2_zero_count", 32'(stall_count), 0);

    // div then mfhi: 10 stall cycles; mult then mfhi: 5
    do_reset();
    mdop(1'b1); step();
    mfhi(); repeat (11) step();
    chk("t3_div_count", 32'(stall_count), 10);
    chk("t3_div_busy", 32'(mdu_busy), 0);
    do_reset();
    mdop(1'b0); step();
    mfhi(); repeat (6) step();
    chk("t3_mult_count", 32'(stall_count), 5);

    // flush discards lw $5 but not the running div
    do_reset();
    mdop(1'b1); step();
    lw(5, 3); step();
    flush = 1'b1; lw(6, 3); step();
    flush = 1'b0;
    set_d(1'b1, 5, 6, 2'b11, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t4_count", 32'(stall_count), 0);
    chk("t4_mdu_busy", 32'(mdu_busy), 1);

    // hold freezes the scoreboard and the stall counter
    do_reset();
    lw(1, 2); step();
    set_d(1'b1, 1, 0, 2'b01, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    hold = 1'b1; repeat (3) step();
    chk("t5_hold_count", 32'(stall_count), 0);
    hold = 1'b0; repeat (3) step();
    chk("t5_count", 32'(stall_count), 2);

    // saturation at 15, then async reset in the middle of a stall
    do_reset();
    repeat (2) begin
      mdop(1'b1); step();
      mfhi(); repeat (11) step();
    end
    chk("t6_sat", 32'(stall_count), SAT);
    mdop(1'b1); step();
    mfhi(); repeat (2) step();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_stall", 32'(stall), 0);
    chk("t6_async_why", 32'(stall_why), 0);
    chk("t6_async_busy", 32'(mdu_busy), 0);
    chk("t6_async_count", 32'(stall_count), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_clear();
    step();

    // random traffic over a few registers to provoke overlaps
    do_reset();
    for (int n = 0; n < 500; n++) begin
      set_d($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 4),
            $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0);
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
